// File: rtl/mdu_if.sv
// Operand/result bundle between the EX stage and the multiply/divide unit.
// master drives the operation and operands; slave returns busy, HI/LO and the mfhi/mflo read.
interface mdu_if;
   logic        op_valid;
   logic [3:0]  MDUop;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] MDUout;

   modport master (
      output op_valid, MDUop, A, B,
      input  busy, HI, LO, MDUout
   );

   modport slave (
      input  op_valid, MDUop, A, B,
      output busy, HI, LO, MDUout
   );
endinterface

// File: rtl/mdu.sv
// MIPS multiply/divide unit owning HI/LO; madd/maddu/msub/msubu only when MDU_MADD_EN is defined.
// Latency: MULT_CYCLES/DIV_CYCLES edges from issue to HI/LO commit; mthi/mtlo next edge; MDUout combinational.
// Backpressure: busy stalls MD-class issue; any MD op seen while busy is dropped without state change.
module mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic clk,
   input  logic reset,
   mdu_if.slave md
);

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MFHI  = 4'd5,
      OP_MFLO  = 4'd6,
      OP_MTHI  = 4'd7,
      OP_MTLO  = 4'd8,
      OP_MADD  = 4'd9,
      OP_MADDU = 4'd10,
      OP_MSUB  = 4'd11,
      OP_MSUBU = 4'd12
   } md_op_e;

   md_op_e             op;
   logic        [3:0]  cnt;
   logic               busy_q;
   logic        [31:0] hi_q;
   logic        [31:0] lo_q;
   logic        [63:0] pend;

   logic               is_md;
   logic               is_mul;
   logic        [63:0] p_nxt;
   logic        [63:0] acc;
   logic signed [63:0] a_ext;
   logic signed [63:0] b_ext;
   logic signed [63:0] prod_s;
   logic        [63:0] prod_u;
   logic signed [31:0] sa;
   logic signed [31:0] sb;
   logic        [31:0] quo_s;
   logic        [31:0] rem_s;
   logic        [31:0] quo_u;
   logic        [31:0] rem_u;

   assign op     = md_op_e'(md.MDUop);
   assign acc    = {hi_q, lo_q};
   assign a_ext  = {{32{md.A[31]}}, md.A};
   assign b_ext  = {{32{md.B[31]}}, md.B};
   assign prod_s = a_ext * b_ext;
   assign prod_u = {32'd0, md.A} * {32'd0, md.B};
   assign sa     = md.A;
   assign sb     = md.B;

   // Divide-by-zero and the single signed overflow case never reach the divider operators.
   always_comb begin
      quo_s = 32'd0;
      rem_s = 32'd0;
      quo_u = 32'd0;
      rem_u = 32'd0;
      if (md.B != 32'd0) begin
         quo_u = md.A / md.B;
         rem_u = md.A % md.B;
         if (md.A == 32'h8000_0000 && md.B == 32'hFFFF_FFFF) begin
            quo_s = 32'h8000_0000;
            rem_s = 32'd0;
         end else begin
            quo_s = sa / sb;
            rem_s = sa % sb;
         end
      end
   end

   always_comb begin
      is_md  = 1'b0;
      is_mul = 1'b1;
      p_nxt  = acc;
      case (op)
         OP_MULT:  begin is_md = 1'b1; p_nxt = prod_s; end
         OP_MULTU: begin is_md = 1'b1; p_nxt = prod_u; end
         OP_DIV: begin
            is_md  = 1'b1;
            is_mul = 1'b0;
            if (md.B != 32'd0) p_nxt = {rem_s, quo_s};
         end
         OP_DIVU: begin
            is_md  = 1'b1;
            is_mul = 1'b0;
            if (md.B != 32'd0) p_nxt = {rem_u, quo_u};
         end
`ifdef MDU_MADD_EN
         OP_MADD:  begin is_md = 1'b1; p_nxt = acc + prod_s; end
         OP_MADDU: begin is_md = 1'b1; p_nxt = acc + prod_u; end
         OP_MSUB:  begin is_md = 1'b1; p_nxt = acc - prod_s; end
         OP_MSUBU: begin is_md = 1'b1; p_nxt = acc - prod_u; end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt    <= 4'd0;
         busy_q <= 1'b0;
         hi_q   <= 32'd0;
         lo_q   <= 32'd0;
         pend   <= 64'd0;
      end else if (busy_q) begin
         cnt <= cnt - 4'd1;
         if (cnt == 4'd1) begin
            busy_q       <= 1'b0;
            {hi_q, lo_q} <= pend;
         end
      end else if (md.op_valid) begin
         if (is_md) begin
            pend   <= p_nxt;
            cnt    <= is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
            busy_q <= 1'b1;
         end else if (op == OP_MTHI) begin
            hi_q <= md.A;
         end else if (op == OP_MTLO) begin
            lo_q <= md.A;
         end
      end
   end

   always_comb begin
      md.MDUout = 32'd0;
      if (op == OP_MFHI) md.MDUout = hi_q;
      else if (op == OP_MFLO) md.MDUout = lo_q;
   end

   assign md.busy = busy_q;
   assign md.HI   = hi_q;
   assign md.LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: vector table through a scoreboard queue, plus async-reset and busy-drop sequences.
module tb_mdu;

`ifdef MDU_MADD_EN
   localparam bit MADD = 1'b1;
`else
   localparam bit MADD = 1'b0;
`endif

   typedef struct {
      logic        vld;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } vec_t;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } exp_t;

   logic  clk;
   logic  reset;
   mdu_if bus ();

   int          n_vec;
   int          n_err;
   exp_t        sb[$];
   vec_t        vecs[$];
   logic [31:0] cur_hi;
   logic [31:0] cur_lo;

   mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .md    (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.op_valid = 1'b0;
      bus.MDUop    = 4'd0;
      bus.A        = 32'd0;
      bus.B        = 32'd0;
   endtask

   // Drives one op at the current negedge, counts busy cycles and compares against the scoreboard.
   task automatic run_one(input vec_t v, input bit inject);
      exp_t        e;
      int          n;
      logic [31:0] last_hi;
      logic [31:0] last_lo;
      sb.push_back('{v.hi, v.lo, v.cyc});
      bus.op_valid = v.vld;
      bus.MDUop    = v.op;
      bus.A        = v.a;
      bus.B        = v.b;
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      n       = 0;
      last_hi = cur_hi;
      last_lo = cur_lo;
      while (bus.busy === 1'b1 && n < 40) begin
         n++;
         last_hi = bus.HI;
         last_lo = bus.LO;
         idle_inputs();
         if (inject && n == 1) begin
            bus.op_valid = 1'b1;
            bus.MDUop    = 4'd8;
            bus.A        = 32'h0000_1234;
         end else if (inject && n == 2) begin
            bus.op_valid = 1'b1;
            bus.MDUop    = 4'd1;
            bus.A        = 32'd7;
            bus.B        = 32'd7;
         end
         @(negedge clk);
      end
      idle_inputs();
      e = sb.pop_front();
      check("busy_cycles", 64'(n), 64'(e.cyc));
      if (n > 0) begin
         check("hold_hi", {32'd0, last_hi}, {32'd0, cur_hi});
         check("hold_lo", {32'd0, last_lo}, {32'd0, cur_lo});
      end
      check("hi", {32'd0, bus.HI}, {32'd0, e.hi});
      check("lo", {32'd0, bus.LO}, {32'd0, e.lo});
      bus.MDUop = 4'd5;
      #1;
      check("mfhi", {32'd0, bus.MDUout}, {32'd0, e.hi});
      bus.MDUop = 4'd6;
      #1;
      check("mflo", {32'd0, bus.MDUout}, {32'd0, e.lo});
      bus.MDUop = 4'd0;
      cur_hi = e.hi;
      cur_lo = e.lo;
   endtask

   initial begin
      n_vec  = 0;
      n_err  = 0;
      cur_hi = 32'd0;
      cur_lo = 32'd0;

      vecs.push_back('{1'b1, 4'd1,  32'hFFFF_FFFF, 32'h2,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 5});
      vecs.push_back('{1'b1, 4'd2,  32'hFFFF_FFFF, 32'h2,  32'h1,         32'hFFFF_FFFE, 5});
      vecs.push_back('{1'b1, 4'd4,  32'd7,         32'd2,  32'd1,         32'd3,         10});
      vecs.push_back('{1'b1, 4'd3,  32'hFFFF_FFF9, 32'd2,  32'hFFFF_FFFF, 32'hFFFF_FFFD, 10});
      vecs.push_back('{1'b1, 4'd3,  32'd5,         32'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFD, 10});
      vecs.push_back('{1'b1, 4'd3,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,  32'h8000_0000, 10});
      vecs.push_back('{1'b1, 4'd7,  32'd0,         32'd0,  32'd0,         32'h8000_0000, 0});
      vecs.push_back('{1'b1, 4'd8,  32'd5,         32'd0,  32'd0,         32'd5,         0});
      vecs.push_back('{1'b1, 4'd9,  32'd3,         32'd4,  32'd0,
                       MADD ? 32'd17 : 32'd5, MADD ? 5 : 0});
      vecs.push_back('{1'b1, 4'd12, 32'h10,        32'h10, MADD ? 32'hFFFF_FFFF : 32'd0,
                       MADD ? 32'hFFFF_FF11 : 32'd5, MADD ? 5 : 0});
      vecs.push_back('{1'b1, 4'd1,  32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd0,  32'd6,         5});
      vecs.push_back('{1'b1, 4'd9,  32'hFFFF_FFFF, 32'd1,  32'd0,
                       MADD ? 32'd5 : 32'd6, MADD ? 5 : 0});
      vecs.push_back('{1'b0, 4'd7,  32'hDEAD_BEEF, 32'd0,  32'd0,         MADD ? 32'd5 : 32'd6, 0});
      vecs.push_back('{1'b1, 4'd13, 32'd99,        32'd0,  32'd0,         MADD ? 32'd5 : 32'd6, 0});
      vecs.push_back('{1'b1, 4'd4,  32'hFFFF_FFFF, 32'd0,  32'd0,         MADD ? 32'd5 : 32'd6, 10});
      vecs.push_back('{1'b1, 4'd4,  32'hFFFF_FFFF, 32'h10, 32'hF,         32'h0FFF_FFFF, 10});
      vecs.push_back('{1'b1, 4'd11, 32'hFFFF_FFFE, 32'd3,  32'hF,
                       MADD ? 32'h1000_0005 : 32'h0FFF_FFFF, MADD ? 5 : 0});
      vecs.push_back('{1'b1, 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                       MADD ? 32'hD : 32'hF, MADD ? 32'h1000_0006 : 32'h0FFF_FFFF, MADD ? 5 : 0});

      reset = 1'b1;
      idle_inputs();
      @(negedge clk);
      @(negedge clk);
      check("rst_busy", {63'd0, bus.busy}, 64'd0);
      check("rst_hi", {32'd0, bus.HI}, 64'd0);
      check("rst_lo", {32'd0, bus.LO}, 64'd0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < vecs.size(); i++)
         run_one(vecs[i], 1'b0);

      // Async reset on busy cycle 3 of a mult: everything clears before any clock edge.
      bus.op_valid = 1'b1;
      bus.MDUop    = 4'd1;
      bus.A        = 32'd2;
      bus.B        = 32'd3;
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      @(negedge clk);
      check("pre_rst_busy", {63'd0, bus.busy}, 64'd1);
      #2 reset = 1'b1;
      #1;
      check("async_busy", {63'd0, bus.busy}, 64'd0);
      check("async_hi", {32'd0, bus.HI}, 64'd0);
      check("async_lo", {32'd0, bus.LO}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (12) @(negedge clk);
      check("post_rst_busy", {63'd0, bus.busy}, 64'd0);
      check("post_rst_hi", {32'd0, bus.HI}, 64'd0);
      check("post_rst_lo", {32'd0, bus.LO}, 64'd0);
      cur_hi = 32'd0;
      cur_lo = 32'd0;

      // Ops presented while busy are dropped; the next mult issues on the first non-busy cycle.
      run_one('{1'b1, 4'd1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5}, 1'b1);
      run_one('{1'b1, 4'd1, 32'd3, 32'd5, 32'd0, 32'd15, 5}, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline.
- Consumes the 4-bit MD operation code produced by instruction decode, along with forwarded rs/rt operand values.
- Owns the HI/LO architectural registers and models multi-cycle latency with a busy counter.
- The hazard unit stalls D-stage MD-class instructions while busy is high.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high for mult/multu/madd/maddu/msub/msubu (legal range 1..15).
- DIV_CYCLES, 10, cycles busy stays high for div/divu (legal range 1..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- op_valid  input  1  EX-stage instruction is valid (not a bubble, not flushed).
- MDUop  input  4  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 madd, 10 maddu, 11 msub, 12 msubu; 13-15 treated as none.
- A  input  32  rs operand (forwarded).
- B  input  32  rt operand (forwarded).
- busy  output  1  multi-cycle operation in flight.
- HI  output  32  committed HI register.
- LO  output  32  committed LO register.
- MDUout  output  32  HI when MDUop=5, LO when MDUop=6, else 0; combinational.

Behaviour:
- Reset (async, any time, including mid-operation):
  - HI=0, LO=0, busy=0, counter=0, pending results=0.
  - The in-flight operation is discarded and never commits.
- Issue condition: op_valid=1, busy=0, MDUop in {1,2,3,4,9,10,11,12}.
  - At the issue edge, compute pHI/pLO from A/B and the current HI/LO, then load the counter with MULT_CYCLES or DIV_CYCLES.
  - busy is registered and equals (counter!=0); it is high starting the cycle after the issue edge.
  - HI/LO remain at their old values while busy is high.
  - On the edge where the counter goes 1->0, HI<=pHI, LO<=pLO and busy drops.
  - Total: the result is visible exactly N edges after the issue edge, where N is the configured cycle count.
- Arithmetic:
  - mult: {HI,LO} = signed(A)*signed(B), 64-bit.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - div/divu with B=0: pHI/pLO are set to the current HI/LO, so the registers are unchanged; busy still runs DIV_CYCLES.
  - div with 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - madd/maddu: {HI,LO} += signed/unsigned 64-bit product.
  - msub/msubu: {HI,LO} -= signed/unsigned 64-bit product.
  - All arithmetic is modulo 2^64; no exceptions.
- mthi/mtlo (op_valid=1, busy=0): HI<=A or LO<=A at the next edge, zero latency, busy unaffected.
- mfhi/mflo: MDUout is a combinational read of the committed HI/LO; op_valid is not required.
- Any MD op presented while busy=1 is ignored, with no state change. The hazard unit guarantees this never happens in normal flow; the bench checks that the state is untouched.
- op_valid=0 or MDUop in {0,13,14,15}: no state change.
- Back-to-back: a new issue is accepted on the first edge where busy=0, i.e. the cycle after the commit edge. Its operands see the just-committed HI/LO, which is required for madd chains.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: MDUop 9-12 behave as specified above.
- Undefined: MDUop 9-12 are treated as none (no issue, no busy, no state change), and accumulate logic is not synthesised.

Test Plan:
- Reset, then mult with A=0xFFFFFFFF, B=0x00000002:
  - busy=1 for exactly 5 cycles.
  - HI/LO hold 0/0 until the commit edge, then become HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - MDUop=5 then returns 0xFFFFFFFF.
- multu with same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles. Then divu A=7, B=2 -> after 10 busy cycles, LO=3, HI=1.
- div with A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Then div with A=5, B=0 -> busy for 10 cycles; HI/LO stay 0xFFFFFFFF/0xFFFFFFFD.
- mthi A=0, mtlo A=5 (each visible the next cycle), then madd with A=3, B=4 -> HI=0, LO=17 after 5 cycles.
  - Then msubu with A=B=0x00000010 -> LO=0xFFFFFF11, HI=0xFFFFFFFF.
  - With MDU_MADD_EN undefined, the same madd leaves HI=0, LO=5 and busy=0.
- mult issued, then reset asserted asynchronously on busy cycle 3 -> busy, HI and LO drop to 0 immediately without waiting for a clock edge; no commit after reset is released.
- During busy, present mtlo A=0x1234 with op_valid=1 -> LO unchanged. Then issue a new mult on the cycle after commit -> accepted, busy high again the next cycle.
